uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter MaxBurst, default 16: the maximum number of bytes one requester may send per grant; legal range 1..255.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports ReqData0 / ReqData1, input, 8 bits: the byte offered by requester 0 / requester 1.
REQ-005 The block SHALL have ports ReqValid0 / ReqValid1, input, 1 bit: requester has a byte on ReqDataN.
REQ-006 The block SHALL have ports ReqLast0 / ReqLast1, input, 1 bit: the offered byte ends the requester's packet.
REQ-007 The block SHALL have ports ReqReady0 / ReqReady1, output, 1 bit: high for exactly the cycle in which the offered byte is taken.
REQ-008 The block SHALL have port TxData, output, 8 bits: registered byte to the shared transmitter.
REQ-009 The block SHALL have port TxValid, output, 1 bit: registered start strobe to the transmitter.
REQ-010 The block SHALL have port TxReady, input, 1 bit: the transmitter is idle (low while a frame is shifting).
REQ-011 The block SHALL have port Grant, output, 2 bits: one-hot current owner, 00 = none.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, ISSUE, HOLD, DRAIN.
REQ-013 IDLE: if TxReady=1 and any ReqValidN=1 -> grant, set Grant, clear the byte count, go to LOAD; otherwise stay in IDLE.
REQ-014 Arbitration: single valid -> that requester wins; both valid -> the requester indicated by the 1-bit priority pointer Prio wins.
REQ-015 LOAD: if ReqValid[g]=1 -> ReqReady[g]=1 for one cycle, latch ReqData[g] into TxData and ReqLast[g] into LastSeen, increment the count, go to ISSUE; if ReqValid[g]=0 -> stay in LOAD with the grant held (packet lock).
REQ-016 ISSUE: TxValid=1 for exactly one cycle, go to HOLD; TxData stays stable until the next LOAD capture.
REQ-017 HOLD: TxValid=0 for one cycle with TxReady ignored, because the transmitter's busy indication lags the strobe by one cycle; go to DRAIN.
REQ-018 DRAIN: wait for TxReady=1; then if LastSeen=1 or count==MaxBurst -> release.
REQ-019 Release SHALL mean: Prio <= index of the other requester, Grant <= 00, go to IDLE.
REQ-020 DRAIN without a release condition SHALL go to LOAD with the same grant, and no re-arbitration.
REQ-021 TxValid SHALL never be high in two consecutive cycles, and SHALL never be high in any cycle where TxReady was 0 in the prior cycle.
REQ-022 Latency: byte acceptance (ReqReady) to TxValid SHALL be exactly 1 cycle; an IDLE grant to ReqReady SHALL be 1 cycle when ReqValid is held.
REQ-023 ReqReady0 and ReqReady1 SHALL never be high together, and ReqReadyN SHALL only be high while Grant[N]=1.
REQ-024 The count SHALL be ceil(log2(MaxBurst+1)) bits wide and SHALL never wrap, because release occurs at count==MaxBurst.
REQ-025 With MaxBurst=1, both requesters continuously valid and ReqLast=0, grants SHALL alternate byte by byte.
REQ-026 A requester dropping ReqValid mid-packet SHALL NOT release the lock; the other requester SHALL wait.
REQ-027 ReqLast SHALL be sampled only on the accepted byte.

Reset
REQ-028 While Reset=1, asynchronously: state=IDLE, TxValid=0, TxData=8'h00, ReqReady0=ReqReady1=0, Grant=00, Prio=0 (requester 0 first), count=0, LastSeen=0.
REQ-029 Reset asserted mid-frame SHALL abort the grant; after deassertion no grant SHALL issue until TxReady=1 is observed in IDLE.

Verification
REQ-030 Requester 0 only, sends 3 bytes A1,B2,C3 with Last on C3 -> three single-cycle TxValid pulses carrying A1,B2,C3 in order, each issued after TxReady returns high; Grant=01 throughout, then 00.
REQ-031 Both requesters valid in the same cycle after reset, 2-byte packets each -> requester 0 packet completes first, then requester 1; Prio ends at 0.
REQ-032 MaxBurst=2, requester 0 streams 5 bytes without Last while requester 1 waits -> sequence is 2 bytes from requester 0, then requester 1's packet, then the next 2 bytes from requester 0.
REQ-033 Requester 1 drops ReqValid for 20 cycles mid-packet while requester 0 is valid -> Grant stays 10, with no ReqReady0 and no TxValid until requester 1 resumes.
REQ-034 Reset pulsed during DRAIN with TxReady=0 -> outputs return to reset values immediately; no TxValid until TxReady=1, then normal arbitration from Prio=0.
REQ-035 Throughout every scenario the checker SHALL hold: TxValid is never high in two consecutive cycles, and ReqReady0 and ReqReady1 are never high in the same cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter: packet-locked grants,
// per-grant burst limit and a round-robin priority pointer flipped on release.
module uart_tx_arbiter #(
    parameter int MaxBurst = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] ReqData0,
    input  logic [7:0] ReqData1,
    input  logic       ReqValid0,
    input  logic       ReqValid1,
    input  logic       ReqLast0,
    input  logic       ReqLast1,
    output logic       ReqReady0,
    output logic       ReqReady1,
    output logic [7:0] TxData,
    output logic       TxValid,
    input  logic       TxReady,
    output logic [1:0] Grant
);

    localparam int CntW = $clog2(MaxBurst + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, HOLD, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              prio_q, prio_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              last_q, last_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;

    logic              sel;
    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;

    assign sel     = grant_q[1];
    assign g_valid = sel ? ReqValid1 : ReqValid0;
    assign g_last  = sel ? ReqLast1  : ReqLast0;
    assign g_data  = sel ? ReqData1  : ReqData0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            prio_q  <= 1'b0;
            count_q <= '0;
            last_q  <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            count_q <= count_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        count_d   = count_q;
        last_d    = last_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ReqReady0 = 1'b0;
        ReqReady1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (TxReady && (ReqValid0 || ReqValid1)) begin
                    if (ReqValid0 && (!ReqValid1 || !prio_q)) grant_d = 2'b01;
                    else                                      grant_d = 2'b10;
                    count_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // An idle owner keeps the grant: the packet stays locked.
                if (g_valid) begin
                    ReqReady0 = !sel;
                    ReqReady1 = sel;
                    data_d    = g_data;
                    last_d    = g_last;
                    count_d   = count_q + 1'b1;
                    valid_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = HOLD;
            // Transmitter busy flag lags the strobe, so skip one cycle here.
            HOLD:  state_d = DRAIN;
            DRAIN: begin
                if (TxReady) begin
                    if (last_q || (count_q == CntW'(MaxBurst))) begin
                        prio_d  = !sel;
                        grant_d = 2'b00;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign TxData  = data_q;
    assign TxValid = valid_q;
    assign Grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three instances (MaxBurst 16, 2, 1),
// a busy-for-4-cycles transmitter model and a protocol monitor.
module tb_uart_tx_arbiter;

    logic       Clock = 1'b0;
    logic       rst;
    logic [7:0] rd [3][2];
    logic       rv [3][2];
    logic       rl [3][2];
    logic       rr [3][2];
    logic [7:0] td [3];
    logic       tv [3];
    logic [1:0] gr [3];
    logic       txr [3];
    logic       force_low [3];
    bit         in_gap [3][2];

    int n_chk = 0;
    int n_pass = 0;
    int viol = 0;

    logic [9:0] log0 [$];
    logic [9:0] log1 [$];
    logic [9:0] log2 [$];

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MB = (g == 0) ? 16 : ((g == 1) ? 2 : 1);
        int busy = 0;
        uart_tx_arbiter #(.MaxBurst(MB)) u_dut (
            .Clock    (Clock),
            .Reset    (rst),
            .ReqData0 (rd[g][0]),
            .ReqData1 (rd[g][1]),
            .ReqValid0(rv[g][0]),
            .ReqValid1(rv[g][1]),
            .ReqLast0 (rl[g][0]),
            .ReqLast1 (rl[g][1]),
            .ReqReady0(rr[g][0]),
            .ReqReady1(rr[g][1]),
            .TxData   (td[g]),
            .TxValid  (tv[g]),
            .TxReady  (txr[g]),
            .Grant    (gr[g])
        );
        // Transmitter model: busy for 4 cycles starting the cycle after a strobe.
        always @(posedge Clock) begin
            if (tv[g])        busy <= 4;
            else if (busy > 0) busy <= busy - 1;
        end
        assign txr[g] = (busy == 0) && !force_low[g];
    end

    initial begin : monitor
        bit prev_tv [3];
        bit prev_txr [3];
        bit prev_acc [3];
        forever begin
            @(negedge Clock);
            for (int k = 0; k < 3; k++) begin
                if (rr[k][0] && rr[k][1]) viol++;
                if ((rr[k][0] && !gr[k][0]) || (rr[k][1] && !gr[k][1])) viol++;
                if (tv[k] && (prev_tv[k] || !prev_txr[k])) viol++;
                if (prev_acc[k] && !tv[k]) viol++;
                if (tv[k]) begin
                    case (k)
                        0: log0.push_back({gr[k], td[k]});
                        1: log1.push_back({gr[k], td[k]});
                        default: log2.push_back({gr[k], td[k]});
                    endcase
                end
                prev_tv[k]  = tv[k];
                prev_txr[k] = txr[k];
                prev_acc[k] = (rr[k][0] && rv[k][0]) || (rr[k][1] && rv[k][1]);
            end
        end
    end

    task automatic send(input int k, input int r, input int n, input logic [63:0] pkt,
                        input bit last_end, input int gap_at, input int gap_len,
                        output bit ok, output int first_wait);
        int w;
        ok = 1'b1;
        first_wait = 0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                rv[k][r] = 1'b0;
                in_gap[k][r] = 1'b1;
                repeat (gap_len) @(posedge Clock);
                #1;
                in_gap[k][r] = 1'b0;
            end
            rd[k][r] = pkt[8*i +: 8];
            rl[k][r] = last_end && (i == n - 1);
            rv[k][r] = 1'b1;
            w = 0;
            do begin
                @(negedge Clock);
                w++;
            end while (!rr[k][r] && w < 200);
            if (!rr[k][r]) begin
                ok = 1'b0;
                break;
            end
            if (i == 0) first_wait = w;
            @(posedge Clock);
            #1;
        end
        rv[k][r] = 1'b0;
        rl[k][r] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        rst = 1'b1;
        @(posedge Clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            force_low[k] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                rd[k][r] = 8'h00; rv[k][r] = 1'b0; rl[k][r] = 1'b0; in_gap[k][r] = 1'b0;
            end
        end
        #1 rst = 1'b1;
        #2;
        n_chk++; if (tv[0] !== 1'b0) $display("FAIL reset_txvalid: got %b want 0", tv[0]); else n_pass++;
        n_chk++; if (td[0] !== 8'h00) $display("FAIL reset_txdata: got %h want 00", td[0]); else n_pass++;
        n_chk++; if (gr[0] !== 2'b00) $display("FAIL reset_grant: got %b want 00", gr[0]); else n_pass++;
        n_chk++; if ({rr[0][1], rr[0][0]} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {rr[0][1], rr[0][0]}); else n_pass++;
        n_chk++; if (gr[2] !== 2'b00) $display("FAIL reset_grant_mb1: got %b want 00", gr[2]); else n_pass++;
        repeat (3) @(posedge Clock);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic [9:0] exp [3] = '{10'h1A1, 10'h1B2, 10'h1C3};
        logic [9:0] got;
        bit ok;
        int fw;
        log0.delete();
        send(0, 0, 3, {40'h0, 8'hC3, 8'hB2, 8'hA1}, 1'b1, -1, 0, ok, fw);
        repeat (12) @(negedge Clock);
        n_chk++; if (ok !== 1'b1) $display("FAIL single_accept: got %b want 1", ok); else n_pass++;
        n_chk++; if (fw !== 2) $display("FAIL single_grant_latency: got %0d want 2", fw); else n_pass++;
        n_chk++; if (log0.size() !== 3) $display("FAIL single_count: got %0d want 3", log0.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < log0.size()) ? log0[i] : 10'h3FF;
            n_chk++; if (got !== exp[i]) $display("FAIL single_byte%0d: got %h want %h", i, got, exp[i]); else n_pass++;
        end
        n_chk++; if (gr[0] !== 2'b00) $display("FAIL single_release: got %b want 00", gr[0]); else n_pass++;
    endtask

    task automatic test_both();
        logic [9:0] exp [6] = '{10'h111, 10'h112, 10'h221, 10'h222, 10'h131, 10'h241};
        logic [9:0] got;
        bit ok0, ok1, ok2, ok3;
        int fw0, fw1;
        pulse_reset();
        log0.delete();
        fork
            send(0, 0, 2, {48'h0, 8'h12, 8'h11}, 1'b1, -1, 0, ok0, fw0);
            send(0, 1, 2, {48'h0, 8'h22, 8'h21}, 1'b1, -1, 0, ok1, fw1);
        join
        fork
            send(0, 0, 1, {56'h0, 8'h31}, 1'b1, -1, 0, ok2, fw0);
            send(0, 1, 1, {56'h0, 8'h41}, 1'b1, -1, 0, ok3, fw1);
        join
        repeat (12) @(negedge Clock);
        n_chk++; if ({ok0, ok1, ok2, ok3} !== 4'hF) $display("FAIL both_accept: got %b want 1111", {ok0, ok1, ok2, ok3}); else n_pass++;
        n_chk++; if (log0.size() !== 6) $display("FAIL both_count: got %0d want 6", log0.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < log0.size()) ? log0[i] : 10'h3FF;
            n_chk++; if (got !== exp[i]) $display("FAIL both_byte%0d: got %h want %h", i, got, exp[i]); else n_pass++;
        end
        n_chk++; if (gr[0] !== 2'b00) $display("FAIL both_release: got %b want 00", gr[0]); else n_pass++;
    endtask

    task automatic test_burst();
        logic [9:0] exp [7] = '{10'h101, 10'h102, 10'h20A, 10'h20B, 10'h103, 10'h104, 10'h105};
        logic [9:0] got;
        bit ok0, ok1;
        int fw0, fw1;
        log1.delete();
        fork
            send(1, 0, 5, {24'h0, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 1'b0, -1, 0, ok0, fw0);
            send(1, 1, 2, {48'h0, 8'h0B, 8'h0A}, 1'b1, -1, 0, ok1, fw1);
        join
        repeat (12) @(negedge Clock);
        n_chk++; if ({ok0, ok1} !== 2'b11) $display("FAIL burst_accept: got %b want 11", {ok0, ok1}); else n_pass++;
        n_chk++; if (log1.size() !== 7) $display("FAIL burst_count: got %0d want 7", log1.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            got = (i < log1.size()) ? log1[i] : 10'h3FF;
            n_chk++; if (got !== exp[i]) $display("FAIL burst_byte%0d: got %h want %h", i, got, exp[i]); else n_pass++;
        end
        n_chk++; if (gr[1] !== 2'b01) $display("FAIL burst_lock_held: got %b want 01", gr[1]); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [9:0] exp [6] = '{10'h151, 10'h261, 10'h152, 10'h262, 10'h153, 10'h263};
        logic [9:0] got;
        bit ok0, ok1;
        int fw0, fw1;
        log2.delete();
        fork
            send(2, 0, 3, {40'h0, 8'h53, 8'h52, 8'h51}, 1'b0, -1, 0, ok0, fw0);
            send(2, 1, 3, {40'h0, 8'h63, 8'h62, 8'h61}, 1'b0, -1, 0, ok1, fw1);
        join
        repeat (12) @(negedge Clock);
        n_chk++; if ({ok0, ok1} !== 2'b11) $display("FAIL alt_accept: got %b want 11", {ok0, ok1}); else n_pass++;
        n_chk++; if (log2.size() !== 6) $display("FAIL alt_count: got %0d want 6", log2.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < log2.size()) ? log2[i] : 10'h3FF;
            n_chk++; if (got !== exp[i]) $display("FAIL alt_byte%0d: got %h want %h", i, got, exp[i]); else n_pass++;
        end
        n_chk++; if (gr[2] !== 2'b00) $display("FAIL alt_release: got %b want 00", gr[2]); else n_pass++;
    endtask

    task automatic test_drop();
        logic [9:0] exp [4] = '{10'h271, 10'h272, 10'h273, 10'h181};
        logic [9:0] got;
        bit ok0, ok1;
        int fw0, fw1;
        int bad;
        int w;
        log0.delete();
        bad = 0;
        fork
            send(0, 1, 3, {40'h0, 8'h73, 8'h72, 8'h71}, 1'b1, 1, 20, ok1, fw1);
            begin
                repeat (2) @(posedge Clock);
                #1;
                send(0, 0, 1, {56'h0, 8'h81}, 1'b1, -1, 0, ok0, fw0);
            end
            begin
                w = 0;
                while (!in_gap[0][1] && w < 300) begin
                    @(negedge Clock);
                    w++;
                end
                n_chk++; if (in_gap[0][1] !== 1'b1) $display("FAIL drop_gap_seen: got %b want 1", in_gap[0][1]); else n_pass++;
                repeat (2) @(negedge Clock);
                repeat (15) begin
                    @(negedge Clock);
                    if (gr[0] !== 2'b10 || rr[0][0] !== 1'b0 || tv[0] !== 1'b0) bad++;
                end
                n_chk++; if (bad !== 0) $display("FAIL drop_lock: got %0d bad cycles want 0", bad); else n_pass++;
            end
        join
        repeat (12) @(negedge Clock);
        n_chk++; if ({ok0, ok1} !== 2'b11) $display("FAIL drop_accept: got %b want 11", {ok0, ok1}); else n_pass++;
        n_chk++; if (log0.size() !== 4) $display("FAIL drop_count: got %0d want 4", log0.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (i < log0.size()) ? log0[i] : 10'h3FF;
            n_chk++; if (got !== exp[i]) $display("FAIL drop_byte%0d: got %h want %h", i, got, exp[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_drain();
        logic [9:0] exp [3] = '{10'h191, 10'h1A5, 10'h2B5};
        logic [9:0] got;
        bit ok0, ok1, ok2;
        int fw0, fw1;
        int bad;
        int w;
        log0.delete();
        bad = 0;
        fork
            send(0, 0, 1, {56'h0, 8'h91}, 1'b1, -1, 0, ok0, fw0);
            begin
                w = 0;
                do begin
                    @(negedge Clock);
                    w++;
                end while (!tv[0] && w < 100);
                @(negedge Clock);
                @(negedge Clock);
                n_chk++; if (gr[0] !== 2'b01) $display("FAIL rstdrain_pre_grant: got %b want 01", gr[0]); else n_pass++;
                #2;
                force_low[0] = 1'b1;
                rst = 1'b1;
                #1;
                n_chk++; if (tv[0] !== 1'b0) $display("FAIL rstdrain_txvalid: got %b want 0", tv[0]); else n_pass++;
                n_chk++; if (td[0] !== 8'h00) $display("FAIL rstdrain_txdata: got %h want 00", td[0]); else n_pass++;
                n_chk++; if (gr[0] !== 2'b00) $display("FAIL rstdrain_grant: got %b want 00", gr[0]); else n_pass++;
                @(posedge Clock);
                #1 rst = 1'b0;
            end
        join
        fork
            send(0, 0, 1, {56'h0, 8'hA5}, 1'b1, -1, 0, ok1, fw0);
            send(0, 1, 1, {56'h0, 8'hB5}, 1'b1, -1, 0, ok2, fw1);
            begin
                repeat (10) begin
                    @(negedge Clock);
                    if (gr[0] !== 2'b00 || tv[0] !== 1'b0) bad++;
                end
                n_chk++; if (bad !== 0) $display("FAIL rstdrain_no_grant: got %0d bad cycles want 0", bad); else n_pass++;
                force_low[0] = 1'b0;
            end
        join
        repeat (12) @(negedge Clock);
        n_chk++; if ({ok0, ok1, ok2} !== 3'b111) $display("FAIL rstdrain_accept: got %b want 111", {ok0, ok1, ok2}); else n_pass++;
        n_chk++; if (log0.size() !== 3) $display("FAIL rstdrain_count: got %0d want 3", log0.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < log0.size()) ? log0[i] : 10'h3FF;
            n_chk++; if (got !== exp[i]) $display("FAIL rstdrain_byte%0d: got %h want %h", i, got, exp[i]); else n_pass++;
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_single();
        test_both();
        test_burst();
        test_alternate();
        test_drop();
        test_reset_drain();
        n_chk++; if (viol !== 0) $display("FAIL protocol_monitor: got %0d violations want 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
